// File: rtl/id_ex_fwd_if.sv
// Bus bundle between decode, the ID/EX forwarding stage and the ALU stage.
// The stage is the slave; the decode/bypass side (or a bench) is the master.
interface id_ex_fwd_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int OP_W    = 5,
  parameter int CTRL_W  = 8,
  parameter int NUM_SRC = 2,
  parameter int NUM_BP  = 2,
  parameter int CNT_W   = 16
) ();
  logic                        id_valid_i;
  logic [OP_W-1:0]             id_alu_op_i;
  logic [NUM_SRC*DATA_W-1:0]   id_src_data_i;
  logic [NUM_SRC*ADDR_W-1:0]   id_src_addr_i;
  logic [NUM_SRC-1:0]          id_src_used_i;
  logic [ADDR_W-1:0]           id_wr_addr_i;
  logic [CTRL_W-1:0]           id_ctrl_i;
  logic [NUM_BP*DATA_W-1:0]    bp_data_i;
  logic [NUM_BP*ADDR_W-1:0]    bp_addr_i;
  logic [NUM_BP-1:0]           bp_wen_i;
  logic [NUM_BP-1:0]           bp_is_load_i;
  logic                        stall_i;
  logic                        flush_i;
  logic                        hazard_o;
  logic                        ex_valid_o;
  logic [OP_W-1:0]             ex_alu_op_o;
  logic [NUM_SRC*DATA_W-1:0]   ex_src_data_o;
  logic [ADDR_W-1:0]           ex_wr_addr_o;
  logic [CTRL_W-1:0]           ex_ctrl_o;
  logic [DATA_W-1:0]           ex_store_data_o;
  logic [CNT_W-1:0]            bubble_cnt_o;

  modport master (
    output id_valid_i, id_alu_op_i, id_src_data_i, id_src_addr_i, id_src_used_i,
           id_wr_addr_i, id_ctrl_i, bp_data_i, bp_addr_i, bp_wen_i, bp_is_load_i,
           stall_i, flush_i,
    input  hazard_o, ex_valid_o, ex_alu_op_o, ex_src_data_o, ex_wr_addr_o,
           ex_ctrl_o, ex_store_data_o, bubble_cnt_o
  );

  modport slave (
    input  id_valid_i, id_alu_op_i, id_src_data_i, id_src_addr_i, id_src_used_i,
           id_wr_addr_i, id_ctrl_i, bp_data_i, bp_addr_i, bp_wen_i, bp_is_load_i,
           stall_i, flush_i,
    output hazard_o, ex_valid_o, ex_alu_op_o, ex_src_data_o, ex_wr_addr_o,
           ex_ctrl_o, ex_store_data_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with priority operand forwarding, load-use bubble
// insertion, stall hold, flush and a saturating bubble counter.
module id_ex_fwd_stage #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int OP_W      = 5,
  parameter int CTRL_W    = 8,
  parameter int NUM_SRC   = 2,
  parameter int NUM_BP    = 2,
  parameter int STORE_SRC = 1,
  parameter int CNT_W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_fwd_if.slave   bus
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [NUM_SRC*DATA_W-1:0] fwd_data_p0;
  logic [NUM_SRC-1:0]        fwd_load_p0;
  logic                      hazard_p0;

  logic                      vld_p1;
  logic [OP_W-1:0]           op_p1;
  logic [NUM_SRC*DATA_W-1:0] src_p1;
  logic [ADDR_W-1:0]         wr_p1;
  logic [CTRL_W-1:0]         ctrl_p1;
  logic [DATA_W-1:0]         store_p1;
  logic [CNT_W-1:0]          cnt_p1;

  // Stage 0: per-operand forward select; channels are scanned oldest to
  // youngest so the lowest matching index overrides the others.
  always_comb begin
    fwd_data_p0 = bus.id_src_data_i;
    fwd_load_p0 = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int c = NUM_BP - 1; c >= 0; c--) begin
        if (bus.bp_wen_i[c] &&
            (bus.bp_addr_i[c*ADDR_W +: ADDR_W] == bus.id_src_addr_i[s*ADDR_W +: ADDR_W]) &&
            (bus.id_src_addr_i[s*ADDR_W +: ADDR_W] != '0)) begin
          fwd_data_p0[s*DATA_W +: DATA_W] = bus.bp_data_i[c*DATA_W +: DATA_W];
          fwd_load_p0[s]                  = bus.bp_is_load_i[c];
        end
      end
    end
    hazard_p0 = bus.id_valid_i && |(fwd_load_p0 & bus.id_src_used_i);
  end

  assign bus.hazard_o = hazard_p0;

  // Stage 1: EX-side register; flush beats stall beats hazard bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      op_p1    <= '0;
      src_p1   <= '0;
      wr_p1    <= '0;
      ctrl_p1  <= '0;
      store_p1 <= '0;
      cnt_p1   <= '0;
    end else if (bus.flush_i || (!bus.stall_i && hazard_p0)) begin
      vld_p1   <= 1'b0;
      op_p1    <= '0;
      src_p1   <= '0;
      wr_p1    <= '0;
      ctrl_p1  <= '0;
      store_p1 <= '0;
      if (!bus.flush_i) cnt_p1 <= sat_inc(cnt_p1);
    end else if (!bus.stall_i) begin
      vld_p1   <= bus.id_valid_i;
      op_p1    <= bus.id_alu_op_i;
      src_p1   <= fwd_data_p0;
      wr_p1    <= bus.id_wr_addr_i;
      ctrl_p1  <= bus.id_ctrl_i;
      store_p1 <= fwd_data_p0[STORE_SRC*DATA_W +: DATA_W];
    end
  end

  assign bus.ex_valid_o      = vld_p1;
  assign bus.ex_alu_op_o     = op_p1;
  assign bus.ex_src_data_o   = src_p1;
  assign bus.ex_wr_addr_o    = wr_p1;
  assign bus.ex_ctrl_o       = ctrl_p1;
  assign bus.ex_store_data_o = store_p1;
  assign bus.bubble_cnt_o    = cnt_p1;

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Scoreboard bench for id_ex_fwd_stage: directed vectors push expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_id_ex_fwd_stage;
  localparam int DW = 32, AW = 5, OW = 5, CW = 8, NS = 2, NB = 2, KW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_fwd_if #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW), .CTRL_W(CW),
                 .NUM_SRC(NS), .NUM_BP(NB), .CNT_W(KW)) bus ();

  id_ex_fwd_stage #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW), .CTRL_W(CW),
                    .NUM_SRC(NS), .NUM_BP(NB), .STORE_SRC(1), .CNT_W(KW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        val;
    logic [4:0]  op;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  used;
    logic [4:0]  wr;
    logic [7:0]  ctrl;
    logic [1:0]  wen, ld;
    logic [4:0]  ba0, ba1;
    logic [31:0] bd0, bd1;
    logic        stall, flush;
  } vec_t;

  typedef struct {
    int          due;
    string       tag;
    logic        v;
    logic [4:0]  op;
    logic [31:0] s0, s1;
    logic [4:0]  wr;
    logic [7:0]  ctrl;
    logic [31:0] st;
    logic [2:0]  cnt;
  } exp_t;

  typedef struct {
    int    due;
    string tag;
    logic  hz;
  } hz_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   ncyc   = 0;
  exp_t ex_q[$];
  hz_t  hz_q[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, req);
  endfunction

  function automatic vec_t mk(logic val, logic [4:0] op, logic [4:0] a0, logic [31:0] d0,
                              logic [4:0] a1, logic [31:0] d1, logic [1:0] used,
                              logic [4:0] wr, logic [7:0] ctrl);
    vec_t v;
    v.val = val; v.op = op; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.used = used; v.wr = wr; v.ctrl = ctrl;
    v.wen = 2'b00; v.ld = 2'b00; v.ba0 = '0; v.ba1 = '0; v.bd0 = '0; v.bd1 = '0;
    v.stall = 1'b0; v.flush = 1'b0;
    return v;
  endfunction

  function automatic vec_t bp(vec_t vi, logic [1:0] wen, logic [1:0] ld,
                              logic [4:0] ba0, logic [31:0] bd0,
                              logic [4:0] ba1, logic [31:0] bd1);
    vec_t v = vi;
    v.wen = wen; v.ld = ld; v.ba0 = ba0; v.bd0 = bd0; v.ba1 = ba1; v.bd1 = bd1;
    return v;
  endfunction

  function automatic exp_t ld_e(logic v, logic [4:0] op, logic [31:0] s0, logic [31:0] s1,
                                logic [4:0] wr, logic [7:0] ctrl, logic [2:0] cnt);
    exp_t e;
    e.due = 0; e.tag = "";
    e.v = v; e.op = op; e.s0 = s0; e.s1 = s1; e.wr = wr; e.ctrl = ctrl;
    e.st = s1; e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t bub_e(logic [2:0] cnt);
    return ld_e(1'b0, '0, '0, '0, '0, '0, cnt);
  endfunction

  task automatic apply(vec_t v);
    bus.id_valid_i    = v.val;
    bus.id_alu_op_i   = v.op;
    bus.id_src_data_i = {v.d1, v.d0};
    bus.id_src_addr_i = {v.a1, v.a0};
    bus.id_src_used_i = v.used;
    bus.id_wr_addr_i  = v.wr;
    bus.id_ctrl_i     = v.ctrl;
    bus.bp_data_i     = {v.bd1, v.bd0};
    bus.bp_addr_i     = {v.ba1, v.ba0};
    bus.bp_wen_i      = v.wen;
    bus.bp_is_load_i  = v.ld;
    bus.stall_i       = v.stall;
    bus.flush_i       = v.flush;
  endtask

  task automatic step(string tag, vec_t v, logic hz, exp_t e);
    hz_t h;
    @(posedge clk);
    #1;
    apply(v);
    h.due = ncyc + 1; h.tag = tag; h.hz = hz;
    hz_q.push_back(h);
    e.due = ncyc + 2; e.tag = tag;
    ex_q.push_back(e);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".valid"}, 32'(bus.ex_valid_o), 32'h0);
    chk({tag, ".op"},    32'(bus.ex_alu_op_o), 32'h0);
    chk({tag, ".src0"},  bus.ex_src_data_o[31:0], 32'h0);
    chk({tag, ".src1"},  bus.ex_src_data_o[63:32], 32'h0);
    chk({tag, ".wr"},    32'(bus.ex_wr_addr_o), 32'h0);
    chk({tag, ".ctrl"},  32'(bus.ex_ctrl_o), 32'h0);
    chk({tag, ".store"}, bus.ex_store_data_o, 32'h0);
    chk({tag, ".cnt"},   32'(bus.bubble_cnt_o), 32'h0);
  endtask

  always @(negedge clk) begin
    hz_t  h;
    exp_t e;
    ncyc++;
    if (hz_q.size() > 0 && hz_q[0].due == ncyc) begin
      h = hz_q.pop_front();
      chk({h.tag, ".hazard"}, 32'(bus.hazard_o), 32'(h.hz));
    end
    if (ex_q.size() > 0 && ex_q[0].due == ncyc) begin
      e = ex_q.pop_front();
      chk({e.tag, ".valid"}, 32'(bus.ex_valid_o), 32'(e.v));
      chk({e.tag, ".op"},    32'(bus.ex_alu_op_o), 32'(e.op));
      chk({e.tag, ".src0"},  bus.ex_src_data_o[31:0], e.s0);
      chk({e.tag, ".src1"},  bus.ex_src_data_o[63:32], e.s1);
      chk({e.tag, ".wr"},    32'(bus.ex_wr_addr_o), 32'(e.wr));
      chk({e.tag, ".ctrl"},  32'(bus.ex_ctrl_o), 32'(e.ctrl));
      chk({e.tag, ".store"}, bus.ex_store_data_o, e.st);
      chk({e.tag, ".cnt"},   32'(bus.bubble_cnt_o), 32'(e.cnt));
    end
  end

  initial begin
    vec_t v_a, v_s, v_ldu, v;
    rst = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    #7;
    chk_zero("reset");
    #1 rst = 1'b0;

    step("prio", bp(mk(1, 3, 3, 32'h1111, 0, 32'h2222, 2'b11, 9, 8'h5A),
                    2'b11, 2'b00, 3, 32'hAAAA0000, 3, 32'h5555),
         1'b0, ld_e(1, 3, 32'hAAAA0000, 32'h2222, 9, 8'h5A, 0));
    step("split", bp(mk(1, 1, 4, 32'h100, 5, 32'h200, 2'b11, 2, 8'h01),
                     2'b11, 2'b00, 5, 32'h22, 4, 32'h11),
         1'b0, ld_e(1, 1, 32'h11, 32'h22, 2, 8'h01, 0));
    step("r0", bp(mk(1, 6, 0, 0, 6, 32'h66, 2'b11, 6, 8'h06),
                  2'b01, 2'b01, 0, 32'hDEAD, 0, 0),
         1'b0, ld_e(1, 6, 0, 32'h66, 6, 8'h06, 0));
    v_ldu = bp(mk(1, 4, 0, 32'h10, 7, 32'h70, 2'b10, 7, 8'hFF), 2'b01, 2'b01, 7, 32'h77, 0, 0);
    step("ldu", v_ldu, 1'b1, bub_e(1));
    v = v_ldu; v.used = 2'b01;
    step("ldu_unused", v, 1'b0, ld_e(1, 4, 32'h10, 32'h77, 7, 8'hFF, 1));
    step("mask", bp(mk(1, 2, 8, 32'h80, 0, 32'h5, 2'b01, 1, 8'h11),
                    2'b11, 2'b01, 8, 32'h88, 8, 32'h99),
         1'b1, bub_e(2));
    step("nomask", bp(mk(1, 2, 8, 32'h80, 0, 32'h5, 2'b01, 1, 8'h11),
                      2'b11, 2'b10, 8, 32'h88, 8, 32'h99),
         1'b0, ld_e(1, 2, 32'h88, 32'h5, 1, 8'h11, 2));
    step("novalid", bp(mk(0, 5, 7, 32'h70, 0, 32'h1, 2'b11, 4, 8'h44),
                       2'b01, 2'b01, 7, 32'h77, 0, 0),
         1'b0, ld_e(0, 5, 32'h77, 32'h1, 4, 8'h44, 2));

    v_a = mk(1, 2, 1, 32'hA0, 2, 32'hA1, 2'b11, 3, 8'h33);
    step("loadA", v_a, 1'b0, ld_e(1, 2, 32'hA0, 32'hA1, 3, 8'h33, 2));
    for (int i = 0; i < 3; i++) begin
      v_s = bp(mk(1, 7, 1, 32'hB0 + i, 2, 32'hB1, 2'b11, 5, 8'h55), 2'b01, 2'b01, 1, 32'hBB, 0, 0);
      v_s.stall = 1'b1;
      step("stall", v_s, 1'b1, ld_e(1, 2, 32'hA0, 32'hA1, 3, 8'h33, 2));
    end
    v_s.flush = 1'b1;
    step("flush", v_s, 1'b1, bub_e(2));
    for (int i = 0; i < 3; i++) step("ldu_rep", v_ldu, 1'b1, bub_e(3'(3 + i)));
    step("preA", v_a, 1'b0, ld_e(1, 2, 32'hA0, 32'hA1, 3, 8'h33, 5));

    @(posedge clk);
    #7;
    chk("pre_rst.valid", 32'(bus.ex_valid_o), 32'h1);
    chk("pre_rst.cnt", 32'(bus.bubble_cnt_o), 32'h5);
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.stall = 1'b1;
    apply(v);
    rst = 1'b1;
    #1;
    chk_zero("arst");
    @(posedge clk);
    #3 rst = 1'b0;

    step("postA", v_a, 1'b0, ld_e(1, 2, 32'hA0, 32'hA1, 3, 8'h33, 0));
    for (int i = 0; i < 8; i++) step("sat", v_ldu, 1'b1, bub_e((i < 7) ? 3'(i + 1) : 3'd7));
    step("tail", mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, ld_e(0, 0, 0, 0, 0, 0, 7));

    for (int i = 0; i < 10 && (ex_q.size() > 0 || hz_q.size() > 0); i++) @(negedge clk);
    #1;
    chk("drain", 32'(ex_q.size() + hz_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/id_ex_fwd_stage.md
# id_ex_fwd_stage

Parametrised ID/EX pipeline register with an N-channel, priority-ordered operand forwarding network. It adds load-use hazard detection with bubble insertion, downstream stall hold, flush, a valid bit, and a saturating bubble counter. It sits between the decode stage and the ALU stage. It captures decoded operands each cycle and overrides any operand whose producer is still in flight in a later stage.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- ADDR_W, 5, register address width
- OP_W, 5, ALU opcode width
- CTRL_W, 8, control bundle width
- NUM_SRC, 2, source operands per instruction
- NUM_BP, 2, bypass channels; index 0 is the youngest producer (EX), highest priority
- STORE_SRC, 1, operand index whose forwarded value also drives store data
- CNT_W, 16, bubble counter width

Ports (all buses flat, channel/operand k occupies bits [k*W +: W]):
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid_i  in  1  decode slot holds a real instruction
- id_alu_op_i  in  OP_W  ALU opcode
- id_src_data_i  in  NUM_SRC*DATA_W  register-file read data
- id_src_addr_i  in  NUM_SRC*ADDR_W  source register addresses
- id_src_used_i  in  NUM_SRC  operand is actually read (gates hazard check)
- id_wr_addr_i  in  ADDR_W  destination register
- id_ctrl_i  in  CTRL_W  control bundle
- bp_data_i  in  NUM_BP*DATA_W  bypass results
- bp_addr_i  in  NUM_BP*ADDR_W  bypass destination addresses
- bp_wen_i  in  NUM_BP  bypass channel writes a register
- bp_is_load_i  in  NUM_BP  channel result is a load whose data is not yet valid
- stall_i  in  1  downstream stall: hold all registers
- flush_i  in  1  squash: load a bubble
- hazard_o  out  1  load-use stall request to PC / IF-ID (combinational)
- ex_valid_o  out  1  registered valid
- ex_alu_op_o  out  OP_W
- ex_src_data_o  out  NUM_SRC*DATA_W  forwarded operands
- ex_wr_addr_o  out  ADDR_W
- ex_ctrl_o  out  CTRL_W
- ex_store_data_o  out  DATA_W  forwarded operand STORE_SRC
- bubble_cnt_o  out  CNT_W  saturating count of hazard bubbles

## Operation
- Forward select, per operand s, independently: choose the lowest channel c with bp_wen_i[c]=1, bp_addr_i[c]==addr[s], addr[s]!=0. Otherwise use id_src_data_i[s]. Operands never share a decision.
- Address 0 is never forwarded; the operand reads as id_src_data_i.
- Load-use hazard: hazard_o=1 when id_valid_i=1 and, for some s with id_src_used_i[s]=1, the selected channel c has bp_is_load_i[c]=1. A lower-priority non-load match does not mask it.
- Next-state priority, first match wins:
  - rst: all zero.
  - flush_i: bubble.
  - stall_i: hold every register.
  - hazard_o: bubble, bubble_cnt_o += 1 unless saturated at all-ones.
  - else load all fields, with ex_valid_o = id_valid_i.
- Bubble: ex_valid_o=0, ex_ctrl_o=0, ex_wr_addr_o=0, ex_alu_op_o=0. The data fields are don't-care and are zeroed.
- ex_store_data_o always equals the forwarded value of operand STORE_SRC at capture.
- flush_i with hazard_o both high: flush wins, and the counter does not increment.
- hazard_o is computed even when stall_i=1; upstream ORs it with its own stall.

## Timing
- Latency: 1 cycle, ID inputs to ex_* outputs.
- hazard_o is combinational from the same cycle's inputs, with no register.
- Reset asserts asynchronously: all outputs go to 0 immediately, including bubble_cnt_o. Release is synchronous to the next clk edge.
- Reset during a stall or hazard discards held state; the first post-reset edge loads normally.
- Counter wraps never: it stays at 2^CNT_W-1.

## Test plan
- Priority: src0 addr=3; ch0 (wen, addr3, 0xAAAA0000); ch1 (wen, addr3, 0x5555). Next edge -> ex_src_data[0]=0xAAAA0000.
- Split forward: src0=r4 matches ch1 (0x11); src1=r5 matches ch0 (0x22). -> operands 0x11 / 0x22; ex_store_data_o=0x22.
- r0: src0 addr=0; ch0 wen addr0 data 0xDEAD; regfile 0. -> operand 0, hazard_o=0.
- Load-use: ch0 is_load addr7, src1=r7 used. -> hazard_o=1 same cycle; next edge ex_valid_o=0, ex_ctrl_o=0, bubble_cnt_o=1. The same case with id_src_used_i[1]=0 -> hazard_o=0.
- Stall/flush: load instr A, then stall_i=1 for 3 cycles with new inputs. -> outputs stay A. Then flush_i=1 with stall_i=1 -> bubble.
- Async reset: assert rst mid-cycle with ex_valid_o=1 and bubble_cnt_o=5. -> all outputs 0 before the next edge.
